// File: rtl/conway_pkg.sv
// Shared types and default widths for the Game of Life generation controller.
package conway_pkg;

  localparam int PERIOD_W_DEF = 16;
  localparam int GEN_W_DEF    = 16;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_WAIT,
    S_STEP,
    S_HALT
  } gen_state_t;

endpackage

// File: rtl/conway_tick_timer.sv
// Inter-generation wait counter: counts up while enabled, done once it reaches the live period.
module conway_tick_timer #(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_i,
  input  logic                en_i,
  input  logic [PERIOD_W-1:0] period_i,
  output logic                done_o
);

  logic [PERIOD_W-1:0] tick_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= '0;
    end else if (clr_i) begin
      tick_q <= '0;
    end else if (en_i && (tick_q != '1)) begin
      tick_q <= tick_q + 1'b1;
    end
  end

  // Compared every cycle so a lowered period takes effect immediately.
  assign done_o = (tick_q >= period_i);

endmodule

// File: rtl/conway_gen_controller.sv
// Sequencer for the Life cell array: board clear, generation strobe, run/pause/step,
// inter-generation delay, saturating generation counter and auto-halt.
//
// state   | meaning
// S_CLEAR | board held in clear, counters reset
// S_IDLE  | waiting for run or step
// S_WAIT  | free-running, counting period clocks before next generation
// S_STEP  | one-cycle enable strobe committing a generation
// S_HALT  | stopped by generation limit or stable board; only clear exits
module conway_gen_controller
  import conway_pkg::*;
#(
  parameter int PERIOD_W = PERIOD_W_DEF,
  parameter int GEN_W    = GEN_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_i,
  input  logic                run_i,
  input  logic                pause_i,
  input  logic                step_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic [GEN_W-1:0]    max_gens_i,
  input  logic                halt_stable_i,
  input  logic                changed_i,
  output logic                grid_clr_o,
  output logic                grid_ena_o,
  output logic [GEN_W-1:0]    gen_count_o,
  output logic                running_o,
  output logic                halted_o,
  output logic                stable_o
);

  gen_state_t        state_q, state_d;
  logic [GEN_W-1:0]  gen_count_q, gen_count_d;
  logic              run_mode_q, run_mode_d;
  logic              stable_q, stable_d;
  logic              timer_done;
  logic [GEN_W:0]    gen_next_wide;
  logic              max_hit;

  conway_tick_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_tick_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (state_q != S_WAIT),
    .en_i     (state_q == S_WAIT),
    .period_i (period_i),
    .done_o   (timer_done)
  );

  // One bit wider so the limit compare is exact even when the counter is saturated.
  assign gen_next_wide = {1'b0, gen_count_q} + 1'b1;
  assign max_hit       = (max_gens_i != '0) && (gen_next_wide >= {1'b0, max_gens_i});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_CLEAR;
      gen_count_q <= '0;
      run_mode_q  <= 1'b0;
      stable_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      gen_count_q <= gen_count_d;
      run_mode_q  <= run_mode_d;
      stable_q    <= stable_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    gen_count_d = gen_count_q;
    run_mode_d  = run_mode_q;
    stable_d    = stable_q;

    case (state_q)
      S_CLEAR: begin
        gen_count_d = '0;
        stable_d    = 1'b0;
        run_mode_d  = 1'b0;
        state_d     = S_IDLE;
      end
      S_IDLE: begin
        if (run_i) begin
          state_d    = S_WAIT;
          run_mode_d = 1'b1;
        end else if (step_i) begin
          state_d    = S_STEP;
          run_mode_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (pause_i) begin
          state_d    = S_IDLE;
          run_mode_d = 1'b0;
        end else if (timer_done) begin
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        gen_count_d = (&gen_count_q) ? gen_count_q : gen_count_q + 1'b1;
        stable_d    = ~changed_i;
        if (halt_stable_i && !changed_i) begin
          state_d = S_HALT;
        end else if (max_hit) begin
          state_d = S_HALT;
        end else if (run_mode_q && !pause_i) begin
          state_d = S_WAIT;
        end else begin
          state_d    = S_IDLE;
          run_mode_d = 1'b0;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_CLEAR;
      end
    endcase

    // Clear overrides everything; an in-flight strobe has already been issued.
    if (clr_i) begin
      state_d = S_CLEAR;
    end
  end

  assign grid_clr_o  = (state_q == S_CLEAR);
  assign grid_ena_o  = (state_q == S_STEP);
  assign halted_o    = (state_q == S_HALT);
  assign running_o   = run_mode_q && ((state_q == S_WAIT) || (state_q == S_STEP));
  assign gen_count_o = gen_count_q;
  assign stable_o    = stable_q;

endmodule
